// File: rtl/credit_ctrl_pkg.sv
// ============================================================================
// Module : credit_ctrl_pkg
// Brief  : Shared widths and state encoding for the credit controller.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package credit_ctrl_pkg;

    localparam int CREDIT_W = 4;
    localparam int DELTA_W  = 2;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } credit_state_e;

endpackage

`default_nettype wire

// File: rtl/credit_ctrl.sv
// ============================================================================
// Module : credit_ctrl
// Brief  : Grants variable-size sends against a credit counter, forwards
//          credit returns and sequences flush/re-initialisation of the pool.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module credit_ctrl
    import credit_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [CREDIT_W-1:0] cfg_credits,
    input  logic                flush,
    input  logic                send_valid,
    input  logic [DELTA_W-1:0]  send_cnt,
    output logic                send_ready,
    input  logic                ret_valid,
    input  logic [DELTA_W-1:0]  ret_cnt,
    input  logic [CREDIT_W-1:0] credit_value,
    output logic                reinit,
    output logic [CREDIT_W-1:0] initial_value,
    output logic                incr_valid,
    output logic [DELTA_W-1:0]  incr,
    output logic                decr_valid,
    output logic [DELTA_W-1:0]  decr,
    output logic                flushing,
    output logic                ret_err
);

    credit_state_e       r_state;
    logic [CREDIT_W-1:0] r_cfg_q;
    logic                r_reinit;
    logic [CREDIT_W-1:0] r_init_val;
    logic                r_incr_valid;
    logic [DELTA_W-1:0]  r_incr;
    logic                r_decr_valid;
    logic [DELTA_W-1:0]  r_decr;
    logic                r_ret_err;

    logic [CREDIT_W:0]   w_avail;
    logic [CREDIT_W+1:0] w_level;
    logic                w_ready;
    logic                w_hs;
    logic                w_ovf;
    logic                w_drained;

    // A decrement already issued but not yet seen in credit_value must be
    // subtracted; pending returns are deliberately ignored.
    assign w_avail = {1'b0, credit_value}
                   - (r_decr_valid ? {3'b000, r_decr} : 5'd0);

    assign w_ready = (r_state == ST_RUN) & ~r_reinit
                   & (send_cnt != 2'd0)
                   & (w_avail >= {3'b000, send_cnt});
    assign w_hs    = send_valid & w_ready;

    // Projected pool level once all in-flight deltas and this return land.
    assign w_level = {2'b00, credit_value}
                   + (r_incr_valid ? {4'b0000, r_incr} : 6'd0)
                   + {4'b0000, ret_cnt}
                   - (r_decr_valid ? {4'b0000, r_decr} : 6'd0);
    assign w_ovf   = ret_valid & (w_level > {2'b00, r_cfg_q});

    assign w_drained = (credit_value == r_cfg_q) & ~r_incr_valid & ~r_decr_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_INIT;
            r_cfg_q      <= '0;
            r_reinit     <= 1'b0;
            r_init_val   <= '0;
            r_incr_valid <= 1'b0;
            r_incr       <= '0;
            r_decr_valid <= 1'b0;
            r_decr       <= '0;
            r_ret_err    <= 1'b0;
        end else begin
            if ((r_state == ST_INIT && ret_valid) || w_ovf) begin
                r_ret_err <= 1'b1;
            end

            if (r_state == ST_INIT) begin
                r_cfg_q      <= cfg_credits;
                r_reinit     <= 1'b1;
                r_init_val   <= cfg_credits;
                r_incr_valid <= 1'b0;
                r_incr       <= '0;
                r_decr_valid <= 1'b0;
                r_decr       <= '0;
            end else begin
                r_reinit     <= 1'b0;
                r_incr_valid <= ret_valid & (ret_cnt != 2'd0);
                r_incr       <= ret_cnt;
                r_decr_valid <= w_hs;
                r_decr       <= w_hs ? send_cnt : 2'd0;
            end

            unique case (r_state)
                ST_INIT:  r_state <= ST_RUN;
                ST_RUN:   if (flush) r_state <= ST_DRAIN;
                ST_DRAIN: if (w_drained) r_state <= ST_INIT;
                default:  r_state <= ST_INIT;
            endcase
        end
    end

    assign send_ready    = w_ready;
    assign reinit        = r_reinit;
    assign initial_value = r_init_val;
    assign incr_valid    = r_incr_valid;
    assign incr          = r_incr;
    assign decr_valid    = r_decr_valid;
    assign decr          = r_decr;
    assign flushing      = (r_state == ST_DRAIN) | (r_state == ST_INIT);
    assign ret_err       = r_ret_err;

endmodule

`default_nettype wire

// File: tb/tb_credit_ctrl.sv
// ============================================================================
// Module : tb_credit_ctrl
// Brief  : Directed plus random bench for credit_ctrl with a credit-pool
//          reference model and a behavioural counter closing the loop.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_credit_ctrl;

    localparam int M_INIT  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;

    logic       clk;
    logic       rst;
    logic [3:0] cfg_credits;
    logic       flush;
    logic       send_valid;
    logic [1:0] send_cnt;
    logic       send_ready;
    logic       ret_valid;
    logic [1:0] ret_cnt;
    logic [3:0] cv;
    logic       reinit;
    logic [3:0] initial_value;
    logic       incr_valid;
    logic [1:0] incr;
    logic       decr_valid;
    logic [1:0] decr;
    logic       flushing;
    logic       ret_err;

    int total = 0;
    int bad   = 0;

    // reference model: mode, captured pool size, in-flight deltas, sticky error
    int m_mode, m_cfg, m_init, m_pinc, m_pdec, outst;
    bit m_reinit, m_err;

    credit_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_credits  (cfg_credits),
        .flush        (flush),
        .send_valid   (send_valid),
        .send_cnt     (send_cnt),
        .send_ready   (send_ready),
        .ret_valid    (ret_valid),
        .ret_cnt      (ret_cnt),
        .credit_value (cv),
        .reinit       (reinit),
        .initial_value(initial_value),
        .incr_valid   (incr_valid),
        .incr         (incr),
        .decr_valid   (decr_valid),
        .decr         (decr),
        .flushing     (flushing),
        .ret_err      (ret_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the parent's credit counter.
    always_ff @(posedge clk) begin
        if (rst)
            cv <= 4'd0;
        else if (reinit)
            cv <= initial_value;
        else
            cv <= cv + (incr_valid ? {2'b00, incr} : 4'd0)
                     - (decr_valid ? {2'b00, decr} : 4'd0);
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        bit rdy, hs, nreinit, nerr;
        int nmode, npinc, npdec, ninit, ncfg;
        bit was_rst;
        #1;
        rdy = (m_mode == M_RUN) && !m_reinit && (send_cnt != 2'd0)
              && (int'(cv) - m_pdec >= int'(send_cnt));
        if (!rst) chk("send_ready", send_ready, rdy);
        hs = send_valid && rdy;
        was_rst = rst;
        if (rst) begin
            nmode = M_INIT; npinc = 0; npdec = 0; ninit = 0; ncfg = 0;
            nreinit = 0; nerr = 0; outst = 0;
        end else begin
            nerr = m_err; ncfg = m_cfg; ninit = m_init; nmode = m_mode;
            if (ret_valid && (m_mode == M_INIT ||
                int'(cv) + m_pinc + int'(ret_cnt) - m_pdec > m_cfg))
                nerr = 1;
            if (m_mode == M_INIT) begin
                ncfg = int'(cfg_credits); ninit = int'(cfg_credits);
                nreinit = 1; npinc = 0; npdec = 0; nmode = M_RUN; outst = 0;
            end else begin
                nreinit = 0;
                npinc = ret_valid ? int'(ret_cnt) : 0;
                npdec = hs ? int'(send_cnt) : 0;
                outst = outst + npdec - npinc;
                if (m_mode == M_RUN && flush)
                    nmode = M_DRAIN;
                else if (m_mode == M_DRAIN && int'(cv) == m_cfg && m_pinc == 0 && m_pdec == 0)
                    nmode = M_INIT;
            end
        end
        @(posedge clk);
        #1;
        m_mode = nmode; m_cfg = ncfg; m_init = ninit; m_pinc = npinc;
        m_pdec = npdec; m_reinit = nreinit; m_err = nerr;
        chk("reinit", reinit, m_reinit);
        if (m_reinit || was_rst) chk("initial_value", initial_value, m_init);
        chk("incr_valid", incr_valid, m_pinc != 0);
        if (m_pinc != 0) chk("incr", incr, m_pinc);
        chk("decr_valid", decr_valid, m_pdec != 0);
        if (m_pdec != 0) chk("decr", decr, m_pdec);
        chk("flushing", flushing, m_mode != M_RUN);
        chk("ret_err", ret_err, m_err);
    endtask

    initial begin
        int reinit_cnt;
        bit done;
        rst = 1; cfg_credits = 4'd5; flush = 0; send_valid = 0; send_cnt = 0;
        ret_valid = 0; ret_cnt = 0;
        m_mode = M_INIT; m_cfg = 0; m_init = 0; m_pinc = 0; m_pdec = 0;
        m_reinit = 0; m_err = 0; outst = 0;

        // reset, then INIT sequence with 5 credits
        tick(); tick();
        chk("rst_reinit", reinit, 0);
        chk("rst_decr_valid", decr_valid, 0);
        chk("rst_incr_valid", incr_valid, 0);
        chk("rst_ret_err", ret_err, 0);
        rst = 0; send_cnt = 2'd2;
        tick();
        chk("c1_reinit", reinit, 1);
        chk("c1_initial_value", initial_value, 5);
        chk("c1_ready", send_ready, 0);
        tick();
        chk("c2_ready", send_ready, 1);

        // back-to-back sends of 2 from 5 credits
        send_valid = 1;
        tick(); tick();
        chk("b2b_blocked", send_ready, 0);
        send_cnt = 2'd1; #1;
        chk("avail1_grant", send_ready, 1);
        tick();
        send_valid = 0;
        tick(); tick();
        chk("b2b_pool_empty", cv, 0);

        // same-cycle send and return, pool of 7
        rst = 1; cfg_credits = 4'd7;
        tick();
        rst = 0;
        tick(); tick();
        send_valid = 1; send_cnt = 2'd3;
        tick();
        send_valid = 0;
        tick();
        chk("sim_cv4", cv, 4);
        send_valid = 1; send_cnt = 2'd2; ret_valid = 1; ret_cnt = 2'd3;
        tick();
        send_valid = 0; ret_valid = 0;
        chk("sim_decr", decr, 2);
        chk("sim_incr", incr, 3);
        tick();
        chk("sim_cv5", cv, 5);

        // flush with 3 credits outstanding
        send_valid = 1; send_cnt = 2'd1;
        tick();
        send_valid = 0;
        tick();
        flush = 1;
        tick();
        flush = 0; send_valid = 1; send_cnt = 2'd1; #1;
        chk("drain_blocked", send_ready, 0);
        chk("drain_flushing", flushing, 1);
        send_valid = 0; ret_valid = 1; ret_cnt = 2'd1;
        tick(); tick(); tick();
        ret_valid = 0;
        reinit_cnt = 0; done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            tick();
            if (reinit) reinit_cnt++;
            if (!flushing) done = 1;
        end
        chk("flush_completes", done, 1);
        chk("flush_reinit_once", reinit_cnt, 1);
        chk("flush_reinit_at_run", reinit, 1);

        // random traffic with legal returns
        for (int i = 0; i < 400; i++) begin
            send_valid  = 1'($urandom_range(0, 1));
            send_cnt    = 2'($urandom_range(0, 3));
            flush       = ($urandom_range(0, 39) == 0);
            cfg_credits = 4'($urandom_range(1, 15));
            if (m_mode != M_INIT && outst > 0 && $urandom_range(0, 1) == 1) begin
                ret_valid = 1;
                ret_cnt   = 2'($urandom_range(0, (outst > 3) ? 3 : outst));
            end else begin
                ret_valid = 0;
                ret_cnt   = 0;
            end
            tick();
        end
        send_valid = 0; ret_valid = 0; flush = 0;
        tick(); tick();

        // over-return sets a sticky error
        rst = 1; cfg_credits = 4'd5;
        tick();
        rst = 0;
        tick(); tick();
        ret_valid = 1; ret_cnt = 2'd2;
        tick();
        ret_valid = 0;
        chk("ovf_err_set", ret_err, 1);
        send_valid = 1; send_cnt = 2'd1;
        tick(); tick(); tick();
        send_valid = 0;
        chk("ovf_err_sticky", ret_err, 1);

        // reset while a decrement is in flight
        send_valid = 1; send_cnt = 2'd1;
        tick();
        send_valid = 0;
        chk("pre_rst_decr_valid", decr_valid, 1);
        rst = 1; cfg_credits = 4'd9;
        tick();
        chk("mid_rst_decr_valid", decr_valid, 0);
        chk("mid_rst_reinit", reinit, 0);
        chk("mid_rst_ret_err", ret_err, 0);
        chk("mid_rst_ready", send_ready, 0);
        rst = 0;
        tick();
        chk("re_c1_reinit", reinit, 1);
        chk("re_c1_initial_value", initial_value, 9);
        send_cnt = 2'd3;
        tick();
        chk("re_c2_ready", send_ready, 1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/credit_ctrl.md
# credit_ctrl

Upstream control stage for the 4-bit `counter` used as a credit pool. It accepts variable-size send requests, grants them only when enough credits remain, and collects credit returns from the sink. It drives the counter's `reinit`/`initial_value`/`incr*`/`decr*` inputs from registers and reads its `value` back. It also sequences flush: block sends, wait for every credit to return, then re-initialise the pool.

## Interface
- No parameters. Credit width is fixed at 4 bits and per-cycle delta width at 2 bits, matching `counter`.
- `clk`  in  1  — sole clock, rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `cfg_credits`  in  4  — pool size; sampled only in INIT.
- `flush`  in  1  — single-cycle pulse; honoured only in RUN.
- `send_valid`  in  1  — send request.
- `send_cnt`  in  2  — credits the request needs, 1..3; 0 is never granted.
- `send_ready`  out  1  — grant. A handshake occurs when `send_valid & send_ready`.
- `ret_valid`  in  1  — credit return; no backpressure.
- `ret_cnt`  in  2  — credits returned, 0..3.
- `credit_value`  in  4  — counter `value` fed back.
- `reinit`, `initial_value[3:0]`, `incr_valid`, `incr[1:0]`, `decr_valid`, `decr[1:0]`  out  — registered outputs to the counter.
- `flushing`  out  1  — high while the state is DRAIN or INIT.
- `ret_err`  out  1  — sticky error flag.

## Operation
- States (shared enum): INIT, RUN, DRAIN. Reset state is INIT.
- INIT:
  - `cfg_q <= cfg_credits`.
  - Output register loads `reinit=1`, `initial_value=cfg_credits`; every other output register loads 0.
  - Next state is RUN, unconditionally.
- RUN:
  - Available credit `avail = credit_value - (decr_valid ? decr : 0)`, computed at 5 bits.
  - `send_ready = (state==RUN) & ~reinit & (send_cnt != 0) & (avail >= send_cnt)`.
  - In-flight `incr` is never counted toward `avail` (conservative).
  - On handshake: `decr_valid<=1`, `decr<=send_cnt`; otherwise `decr_valid<=0`.
- Returns, in every state except INIT: `incr_valid <= ret_valid & (ret_cnt!=0)`, `incr <= ret_cnt`.
- Returns arriving in INIT are dropped and set `ret_err`.
- Overflow check: if `credit_value + (incr_valid?incr:0) + ret_cnt - (decr_valid?decr:0) > cfg_q` at 6 bits while `ret_valid`, set `ret_err`. The return is still forwarded.
- `flush` in RUN → DRAIN. In DRAIN `send_ready=0`.
- DRAIN → INIT when `credit_value == cfg_q & ~incr_valid & ~decr_valid`.
- `flush` in DRAIN or INIT is ignored.
- `ret_err` clears only on `rst`.

## Timing
- `send_ready` is combinational from state, the output registers, `credit_value` and `send_cnt`. It never depends on `send_valid`.
- Send handshake at cycle N → `decr_valid=1` at N+1 → `credit_value` reflects the decrement at N+2.
- Return at N → `incr_valid` at N+1 → visible at N+2.
- Simultaneous send and return in the same cycle both propagate in the same N+1 cycle. The counter applies `+incr-decr` together.
- After `rst`, all outputs are 0, `state=INIT`, and `ret_err=0`.
  - At cycle 1, `reinit=1` and `initial_value=cfg_credits`.
  - `send_ready` can first rise at cycle 2.
- `rst` asserted mid-DRAIN or mid-send: any pending handshake is discarded (outputs cleared), and the sequence restarts from INIT.
- Flush latency = cycles until all credits return + 1 (DRAIN→INIT) + 1 (INIT→RUN, `reinit` visible). `flushing` drops in the first RUN cycle.

## Structure
- Package `credit_ctrl_pkg`:
  - State enum `credit_state_e`.
  - `CREDIT_W=4`, `DELTA_W=2`.
- No sub-module. The block is a single FSM plus an output register bank. The counter is instantiated by the parent, not inside this block.

## Test plan
- Reset with `cfg_credits=5` → cycle 1: `reinit=1`, `initial_value=5`. Cycle 2: `send_ready=1` for `send_cnt=2`.
- Back-to-back sends (`send_cnt=2`) every cycle from 5 credits → two grants, then `send_ready=0` with `avail=1`. A request with `send_cnt=1` is then granted.
- Same-cycle send 2 and return 3 from `credit_value=4` → N+1: `decr=2`, `incr=3`. N+2: `credit_value=5`.
- `flush` with 3 credits outstanding → `send_ready=0`. After the last return, DRAIN→INIT→RUN. `reinit=1` occurs exactly once, and `flushing` falls when the state reaches RUN.
- Return of 2 when `credit_value == cfg_q = 5` → `ret_err=1` and stays set through later traffic until `rst`.
- `rst` pulse while `decr_valid=1` → next cycle all outputs are 0, then the INIT sequence repeats with the new `cfg_credits=9`.
